// File: rtl/param_update_scheduler_pkg.sv
// Shared types and constants for the parameter update scheduler and its users.
package param_update_scheduler_pkg;

  // Parameter bank slot assignment used by the neuron/synapse/muscle datapath
  localparam int PIDX_LCE     = 0;
  localparam int PIDX_TAU     = 1;
  localparam int PIDX_LTP     = 2;
  localparam int PIDX_LTD     = 3;
  localparam int PIDX_PDELTA  = 4;
  localparam int PIDX_SYNGAIN = 5;
  localparam int PIDX_CLKDIV  = 6;

  // Typical power-on values for the floating-point and gain parameters
  localparam logic [31:0] RST_LCE     = 32'h3f8ccccd;
  localparam logic [31:0] RST_TAU     = 32'h3cf5c28f;
  localparam logic [31:0] RST_SYNGAIN = 32'd1024;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } commit_state_t;

endpackage

// File: rtl/param_update_scheduler_fifo.sv
// Synchronous FIFO holding pending {idx, data} parameter writes.
// A pop on an empty FIFO is ignored; a push while full succeeds only if a pop
// frees the head slot in the same cycle.
module param_update_scheduler_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 35
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/param_update_scheduler.sv
// Queues host parameter writes and commits them into the parameter bank only
// inside a short window opened by sim_tick, so the datapath sees changes on
// simulation-step boundaries.
module param_update_scheduler
  import param_update_scheduler_pkg::*;
#(
  parameter int              NP         = 8,
  parameter int              DEPTH      = 8,
  parameter int              MAX_COMMIT = 4,
  parameter logic [NP*32-1:0] RESET_VALS = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NP-1:0]     trig,
  input  logic [31:0]       data_in,
  input  logic              sim_tick,
  output logic [NP*32-1:0]  params_out,
  output logic [NP-1:0]     param_updated,
  output logic              busy,
  output logic              q_full,
  output logic [15:0]       drop_cnt
);

  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int EW = IW + 32;
  localparam int NW = $clog2(MAX_COMMIT + 1);

  logic [NP-1:0]         mask;
  logic [31:0]           data_r;
  logic [IW-1:0]         lo_idx;
  logic                  split_go;
  logic                  q_empty;
  logic                  q_pop;
  logic [EW-1:0]         pop_entry;
  logic [IW-1:0]         pop_idx;
  logic [31:0]           pop_data;
  commit_state_t         state, state_nxt;
  logic [NW-1:0]         n_commit;
  logic [NP-1:0][31:0]   params_q;
  logic [NP-1:0]         upd_pend;

  assign busy       = (mask != '0);
  assign split_go   = busy && !q_full;
  assign pop_idx    = pop_entry[EW-1:32];
  assign pop_data   = pop_entry[31:0];
  assign params_out = params_q;

  // Lowest set bit of the pending mask: the next index to enqueue
  always_comb begin
    lo_idx = '0;
    for (int i = NP-1; i >= 0; i--)
      if (mask[i]) lo_idx = IW'(i);
  end

  // Capture a trig word when idle, peel one index per cycle into the queue,
  // and count trig words that arrive while a previous one is still splitting
  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      data_r   <= '0;
      drop_cnt <= '0;
    end else if (trig != '0 && mask == '0) begin
      mask   <= trig;
      data_r <= data_in;
    end else begin
      if (split_go) mask <= mask & (mask - NP'(1));
      if (trig != '0 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  param_update_scheduler_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (split_go),
    .push_data ({lo_idx, data_r}),
    .pop       (q_pop),
    .pop_data  (pop_entry),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Commit FSM state and per-window write counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      n_commit <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) n_commit <= '0;
      else if (q_pop)       n_commit <= n_commit + NW'(1);
    end
  end

  // Commit FSM next state; the window closes on an empty queue or a full budget
  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    case (state)
      ST_IDLE:   if (sim_tick) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        if (q_empty || n_commit == NW'(MAX_COMMIT)) state_nxt = ST_IDLE;
        else                                          q_pop     = 1'b1;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Parameter bank; the update strobe trails the register write by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      params_q      <= RESET_VALS;
      upd_pend      <= '0;
      param_updated <= '0;
    end else begin
      upd_pend <= '0;
      if (q_pop) begin
        params_q[pop_idx] <= pop_data;
        upd_pend[pop_idx] <= 1'b1;
      end
      param_updated <= upd_pend;
    end
  end

endmodule

// File: tb/tb_param_update_scheduler.sv
// Bench for param_update_scheduler: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_param_update_scheduler;
  import param_update_scheduler_pkg::*;

  localparam int NP    = 8;
  localparam int DEPTH = 8;
  localparam int MAXC  = 4;
  localparam logic [NP*32-1:0] RV = {32'hA5A50007, 32'd4, RST_SYNGAIN, 32'd0,
                                     32'd0, 32'd0, RST_TAU, RST_LCE};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     trig = '0;
  logic [31:0]       data_in = '0;
  logic              sim_tick = 1'b0;
  logic [NP*32-1:0]  params_out;
  logic [NP-1:0]     param_updated;
  logic              busy, q_full;
  logic [15:0]       drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_params [NP];
  logic [34:0] m_q [$];
  logic [7:0]  m_mask, m_pend, m_upd;
  logic [31:0] m_data;
  logic        m_commit;
  int          m_n;
  logic [15:0] m_drop;

  param_update_scheduler #(
    .NP(NP), .DEPTH(DEPTH), .MAX_COMMIT(MAXC), .RESET_VALS(RV)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig), .data_in(data_in), .sim_tick(sim_tick),
    .params_out(params_out), .param_updated(param_updated), .busy(busy),
    .q_full(q_full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rv(input int i);
    logic [NP*32-1:0] v;
    v = RV;
    return v[i*32 +: 32];
  endfunction

  function automatic logic [31:0] dut_p(input int i);
    return params_out[i*32 +: 32];
  endfunction

  function automatic logic [NP*32-1:0] model_vec();
    logic [NP*32-1:0] v;
    for (int i = 0; i < NP; i++) v[i*32 +: 32] = m_params[i];
    return v;
  endfunction

  // One clock: drive inputs, advance the model with the same inputs, settle to negedge
  task automatic step(input logic r, input logic [7:0] t, input logic [31:0] d, input logic tk);
    logic [34:0] e;
    int          sz0;
    logic [7:0]  mask0;
    int          k;
    reset = r; trig = t; data_in = d; sim_tick = tk;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NP; i++) m_params[i] = rv(i);
      m_q.delete();
      m_mask = '0; m_data = '0; m_commit = 1'b0; m_n = 0;
      m_pend = '0; m_upd = '0; m_drop = '0;
    end else begin
      sz0   = m_q.size();
      mask0 = m_mask;
      m_upd  = m_pend;
      m_pend = '0;
      if (m_commit) begin
        if (sz0 == 0 || m_n == MAXC) m_commit = 1'b0;
        else begin
          e = m_q.pop_front();
          m_params[e[34:32]] = e[31:0];
          m_pend[e[34:32]]   = 1'b1;
          m_n++;
        end
      end else if (tk) begin
        m_commit = 1'b1;
        m_n      = 0;
      end
      if (mask0 != 0 && sz0 < DEPTH) begin
        k = 0;
        while (!mask0[k]) k++;
        m_q.push_back({k[2:0], m_data});
        m_mask[k] = 1'b0;
      end
      if (t != 0) begin
        if (mask0 == 0) begin
          m_mask = t;
          m_data = d;
        end else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 8'hFF, 32'h12345678, 1'b1);
    step(1'b1, '0, '0, 1'b0);
    n_checks++;
    if (params_out !== RV) begin n_errors++; $display("FAIL reset_params got=%h exp=%h", params_out, RV); end
    n_checks++;
    if ({q_full, busy} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got q_full=%b busy=%b exp 0 0", q_full, busy); end
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_drop got=%h exp=0", drop_cnt); end
    step(1'b0, '0, '0, 1'b0);
    n_checks++;
    if (param_updated !== 8'h00) begin n_errors++; $display("FAIL reset_updated got=%h exp=00", param_updated); end
  endtask

  task automatic test_single();
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 8'h02, 32'h3d4ccccd, 1'b0);
    idle(4);
    n_checks++;
    if (dut_p(1) !== rv(1)) begin n_errors++; $display("FAIL single_hold got=%h exp=%h", dut_p(1), rv(1)); end
    step(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (dut_p(1) !== rv(1)) begin n_errors++; $display("FAIL single_tick0 got=%h exp=%h", dut_p(1), rv(1)); end
    idle(1);
    n_checks++;
    if (dut_p(1) !== 32'h3d4ccccd || param_updated !== 8'h00) begin
      n_errors++; $display("FAIL single_write got=%h upd=%h exp=3d4ccccd upd=00", dut_p(1), param_updated);
    end
    idle(1);
    n_checks++;
    if (param_updated !== 8'h02) begin n_errors++; $display("FAIL single_pulse got=%h exp=02", param_updated); end
    idle(1);
    n_checks++;
    if (param_updated !== 8'h00) begin n_errors++; $display("FAIL single_pulse_end got=%h exp=00", param_updated); end
  endtask

  task automatic test_multi_bit();
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 8'h0C, 32'd5, 1'b0);
    idle(3);
    step(1'b0, '0, '0, 1'b1);
    idle(1);
    n_checks++;
    if (dut_p(2) !== 32'd5 || dut_p(3) !== rv(3)) begin
      n_errors++; $display("FAIL multi_first got p2=%h p3=%h exp p2=5 p3=%h", dut_p(2), dut_p(3), rv(3));
    end
    idle(1);
    n_checks++;
    if (dut_p(3) !== 32'd5 || param_updated !== 8'h04) begin
      n_errors++; $display("FAIL multi_second got p3=%h upd=%h exp p3=5 upd=04", dut_p(3), param_updated);
    end
    idle(1);
    n_checks++;
    if (param_updated !== 8'h08) begin n_errors++; $display("FAIL multi_pulse got=%h exp=08", param_updated); end
  endtask

  task automatic test_max_commit();
    step(1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'(1 << i), 32'h100 + 32'(i), 1'b0);
      idle(1);
    end
    step(1'b0, '0, '0, 1'b1);
    idle(1);
    step(1'b0, '0, '0, 1'b1);
    idle(6);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (dut_p(i) !== ((i < MAXC) ? 32'h100 + 32'(i) : rv(i))) begin
        n_errors++; $display("FAIL max_window1 p%0d got=%h", i, dut_p(i));
      end
    end
    step(1'b0, '0, '0, 1'b1);
    idle(6);
    n_checks++;
    if (dut_p(4) !== 32'h104 || dut_p(5) !== 32'h105) begin
      n_errors++; $display("FAIL max_window2 got p4=%h p5=%h exp 104 105", dut_p(4), dut_p(5));
    end
    n_checks++;
    if (params_out !== model_vec()) begin n_errors++; $display("FAIL max_model got=%h exp=%h", params_out, model_vec()); end
  endtask

  task automatic test_drop_full();
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 8'hFF, 32'hAAAA0001, 1'b0);
    step(1'b0, 8'h01, 32'hBBBB0000, 1'b0);
    n_checks++;
    if (drop_cnt !== 16'd1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL drop_count got cnt=%0d busy=%b exp cnt=1 busy=1", drop_cnt, busy);
    end
    idle(7);
    n_checks++;
    if (q_full !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL full_flag got q_full=%b busy=%b exp 1 0", q_full, busy);
    end
    step(1'b0, 8'h01, 32'hCCCC0002, 1'b0);
    idle(3);
    n_checks++;
    if (q_full !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL full_stall got q_full=%b busy=%b exp 1 1", q_full, busy);
    end
    for (int w = 0; w < 3; w++) begin
      step(1'b0, '0, '0, 1'b1);
      idle(8);
    end
    n_checks++;
    if (dut_p(0) !== 32'hCCCC0002) begin n_errors++; $display("FAIL full_last_wins got=%h exp=cccc0002", dut_p(0)); end
    for (int i = 1; i < NP; i++) begin
      n_checks++;
      if (dut_p(i) !== 32'hAAAA0001) begin n_errors++; $display("FAIL full_fanout p%0d got=%h exp=aaaa0001", i, dut_p(i)); end
    end
    n_checks++;
    if (drop_cnt !== 16'd1 || busy !== 1'b0 || q_full !== 1'b0) begin
      n_errors++; $display("FAIL full_drain got cnt=%0d busy=%b q_full=%b exp 1 0 0", drop_cnt, busy, q_full);
    end
  endtask

  task automatic test_reset_mid_commit();
    logic [7:0] seen;
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 8'h70, 32'hDEAD0003, 1'b0);
    idle(4);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, '0, '0, 1'b0);
    n_checks++;
    if (params_out !== RV || busy !== 1'b0 || q_full !== 1'b0) begin
      n_errors++; $display("FAIL midreset_state got=%h busy=%b q_full=%b", params_out, busy, q_full);
    end
    step(1'b0, '0, '0, 1'b1);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      seen |= param_updated;
    end
    n_checks++;
    if (params_out !== RV || seen !== 8'h00) begin
      n_errors++; $display("FAIL midreset_empty got=%h upd=%h exp=%h upd=00", params_out, seen, RV);
    end
  endtask

  task automatic test_random();
    logic [7:0]  t;
    logic        tk;
    step(1'b1, '0, '0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      t  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      tk = ($urandom_range(0, 15) == 0);
      step(($urandom_range(0, 999) == 0), t, $urandom, tk);
      n_checks++;
      if (params_out !== model_vec()) begin
        n_errors++; $display("FAIL rand_params cyc=%0d got=%h exp=%h", c, params_out, model_vec());
      end
      n_checks++;
      if (param_updated !== m_upd) begin
        n_errors++; $display("FAIL rand_updated cyc=%0d got=%h exp=%h", c, param_updated, m_upd);
      end
      n_checks++;
      if (busy !== (m_mask != 0) || q_full !== (m_q.size() == DEPTH)) begin
        n_errors++; $display("FAIL rand_flags cyc=%0d got busy=%b q_full=%b exp %b %b",
                             c, busy, q_full, (m_mask != 0), (m_q.size() == DEPTH));
      end
      n_checks++;
      if (drop_cnt !== m_drop) begin
        n_errors++; $display("FAIL rand_drop cyc=%0d got=%0d exp=%0d", c, drop_cnt, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_bit();
    test_max_commit();
    test_drop_full();
    test_reset_mid_commit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
